// File: rtl/mc_pkg.sv
// mc_pkg: shared constants and types for the 16-bit multicycle MIPS controller.
//   - opcode map (IR[15:12])
//   - ALU control encodings
//   - alu_src_b select encodings
//   - controller state enumeration (4-bit, also exported on the state port)
//   - instruction class produced by mc_op_class
//   - bundle of state-decoded (Moore) control outputs held in a register
package mc_pkg;

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b0001;
  localparam logic [3:0] OP_AND  = 4'b0010;
  localparam logic [3:0] OP_OR   = 4'b0011;
  localparam logic [3:0] OP_ADDI = 4'b0100;
  localparam logic [3:0] OP_LW   = 4'b0101;
  localparam logic [3:0] OP_SW   = 4'b0110;
  localparam logic [3:0] OP_SLT  = 4'b0111;
  localparam logic [3:0] OP_BEQ  = 4'b1000;
  localparam logic [3:0] OP_BNE  = 4'b1001;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  localparam logic [1:0] SRCB_B      = 2'b00;
  localparam logic [1:0] SRCB_TWO    = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;

  typedef enum logic [3:0] {
    S_IDLE     = 4'd0,
    S_FETCH    = 4'd1,
    S_DECODE   = 4'd2,
    S_EXEC_R   = 4'd3,
    S_EXEC_I   = 4'd4,
    S_MEM_ADDR = 4'd5,
    S_MEM_RD   = 4'd6,
    S_MEM_WR   = 4'd7,
    S_WB_ALU   = 4'd8,
    S_WB_MEM   = 4'd9,
    S_BRANCH   = 4'd10,
    S_HALT     = 4'd11
  } state_t;

  typedef enum logic [2:0] {
    CL_R   = 3'd0,
    CL_I   = 3'd1,
    CL_MEM = 3'd2,
    CL_BR  = 3'd3,
    CL_ILL = 3'd4
  } op_class_t;

  // Control outputs that depend only on the state; held in a register that
  // is loaded together with the state register.
  typedef struct packed {
    logic       mem_req;
    logic       mem_we;
    logic       iord;
    logic       pc_write_cond;
    logic       branch_ne;
    logic       pc_src;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_ctrl;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic       done;
    logic       halted;
  } ctrl_t;

endpackage

// File: rtl/mc_op_class.sv
// mc_op_class: combinational opcode decoder.
//   opcode   in  4  IR[15:12]
//   op_class out    instruction class (R, I, MEM, BR, ILL)
//   alu_ctrl out 3  ALU operation for R-type; ADD for every other opcode
//   illegal  out 1  opcode outside the supported set
module mc_op_class
  import mc_pkg::*;
(
  input  logic [3:0] opcode,
  output op_class_t  op_class,
  output logic [2:0] alu_ctrl,
  output logic       illegal
);

  always_comb begin
    op_class = CL_ILL;
    alu_ctrl = ALU_ADD;
    illegal  = 1'b0;
    case (opcode)
      OP_ADD:  begin op_class = CL_R; alu_ctrl = ALU_ADD; end
      OP_SUB:  begin op_class = CL_R; alu_ctrl = ALU_SUB; end
      OP_AND:  begin op_class = CL_R; alu_ctrl = ALU_AND; end
      OP_OR:   begin op_class = CL_R; alu_ctrl = ALU_OR;  end
      OP_SLT:  begin op_class = CL_R; alu_ctrl = ALU_SLT; end
      OP_ADDI: op_class = CL_I;
      OP_LW,
      OP_SW:   op_class = CL_MEM;
      OP_BEQ,
      OP_BNE:  op_class = CL_BR;
      default: begin
        op_class = CL_ILL;
        illegal  = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: control FSM sequencing a 16-bit multicycle MIPS datapath
// with one shared ALU and one req/ack memory port.
//   clk, rst_n              clock, asynchronous active-low reset
//   opcode, zero, mem_ack   IR[15:12], ALU zero flag, memory completion
//   mem_req, mem_we, iord   memory request, write, address select
//   ir_write, pc_write      IR / PC load (qualified by mem_ack in FETCH)
//   pc_write_cond,
//   branch_ne, pc_src       conditional PC load controls for BEQ/BNE
//   alu_src_a, alu_src_b,
//   alu_ctrl                ALU operand selects and operation
//   reg_dst, mem_to_reg,
//   reg_write               register file write controls
//   instr_done              pulse on the final cycle of each instruction
//   halted                  sticky illegal-opcode indicator
//   state                   current state encoding
// State-only outputs come from a register loaded alongside the state, so
// they equal a decode of the current state; only ir_write, pc_write and the
// SW completion pulse look at mem_ack combinationally.
module multicycle_ctrl
  import mc_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] opcode,
  input  logic       zero,
  input  logic       mem_ack,
  output logic       mem_req,
  output logic       mem_we,
  output logic       iord,
  output logic       ir_write,
  output logic       pc_write,
  output logic       pc_write_cond,
  output logic       branch_ne,
  output logic       pc_src,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [2:0] alu_ctrl,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       reg_write,
  output logic       instr_done,
  output logic       halted,
  output logic [3:0] state
);

  state_t    state_q, state_d;
  ctrl_t     ctrl_q, ctrl_d;
  op_class_t dec_class;
  logic [2:0] dec_alu_ctrl;
  logic      dec_illegal;

  mc_op_class u_op_class (
    .opcode   (opcode),
    .op_class (dec_class),
    .alu_ctrl (dec_alu_ctrl),
    .illegal  (dec_illegal)
  );

  // Moore outputs for state s. r_alu, rd_sel and bne are sampled on the
  // transition into s, while the opcode of the current instruction is valid.
  function automatic ctrl_t ctrl_for(input state_t s, input logic [2:0] r_alu,
                                     input logic rd_sel, input logic bne);
    ctrl_t c;
    c = '0;
    case (s)
      S_FETCH: begin
        c.mem_req   = 1'b1;
        c.alu_src_b = SRCB_TWO;
        c.alu_ctrl  = ALU_ADD;
      end
      S_DECODE: begin
        c.alu_src_b = SRCB_IMM_SH;
        c.alu_ctrl  = ALU_ADD;
      end
      S_EXEC_R: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = SRCB_B;
        c.alu_ctrl  = r_alu;
      end
      S_EXEC_I, S_MEM_ADDR: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = SRCB_IMM;
        c.alu_ctrl  = ALU_ADD;
      end
      S_MEM_RD: begin
        c.mem_req = 1'b1;
        c.iord    = 1'b1;
      end
      S_MEM_WR: begin
        c.mem_req = 1'b1;
        c.iord    = 1'b1;
        c.mem_we  = 1'b1;
      end
      S_WB_ALU: begin
        c.reg_write = 1'b1;
        c.reg_dst   = rd_sel;
        c.done      = 1'b1;
      end
      S_WB_MEM: begin
        c.reg_write  = 1'b1;
        c.mem_to_reg = 1'b1;
        c.done       = 1'b1;
      end
      S_BRANCH: begin
        c.alu_src_a     = 1'b1;
        c.alu_src_b     = SRCB_B;
        c.alu_ctrl      = ALU_SUB;
        c.pc_write_cond = 1'b1;
        c.pc_src        = 1'b1;
        c.branch_ne     = bne;
        c.done          = 1'b1;
      end
      S_HALT: c.halted = 1'b1;
      default: c = '0;
    endcase
    return c;
  endfunction

  // mem_ack only matters in the three request states, so an ack with
  // mem_req low never changes anything.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   state_d = S_FETCH;
      S_FETCH:  if (mem_ack) state_d = S_DECODE;
      S_DECODE: begin
        if (dec_illegal) begin
          state_d = S_HALT;
        end else begin
          case (dec_class)
            CL_R:    state_d = S_EXEC_R;
            CL_I:    state_d = S_EXEC_I;
            CL_MEM:  state_d = S_MEM_ADDR;
            CL_BR:   state_d = S_BRANCH;
            default: state_d = S_HALT;
          endcase
        end
      end
      S_EXEC_R,
      S_EXEC_I:   state_d = S_WB_ALU;
      S_MEM_ADDR: state_d = (opcode == OP_LW) ? S_MEM_RD : S_MEM_WR;
      S_MEM_RD:   if (mem_ack) state_d = S_WB_MEM;
      S_MEM_WR:   if (mem_ack) state_d = S_FETCH;
      S_WB_ALU,
      S_WB_MEM,
      S_BRANCH:   state_d = S_FETCH;
      S_HALT:     state_d = S_HALT;
      default:    state_d = S_IDLE;
    endcase
    ctrl_d = ctrl_for(state_d, dec_alu_ctrl, state_q == S_EXEC_R, opcode[0]);
  end

  // State register boundary: state and its decoded outputs load together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      ctrl_q  <= '0;
    end else begin
      state_q <= state_d;
      ctrl_q  <= ctrl_d;
    end
  end

  assign mem_req       = ctrl_q.mem_req;
  assign mem_we        = ctrl_q.mem_we;
  assign iord          = ctrl_q.iord;
  assign pc_write_cond = ctrl_q.pc_write_cond;
  assign branch_ne     = ctrl_q.branch_ne;
  assign pc_src        = ctrl_q.pc_src;
  assign alu_src_a     = ctrl_q.alu_src_a;
  assign alu_src_b     = ctrl_q.alu_src_b;
  assign alu_ctrl      = ctrl_q.alu_ctrl;
  assign reg_dst       = ctrl_q.reg_dst;
  assign mem_to_reg    = ctrl_q.mem_to_reg;
  assign reg_write     = ctrl_q.reg_write;
  assign halted        = ctrl_q.halted;
  assign state         = state_q;

  // Mealy qualifications on the memory acknowledge.
  assign ir_write   = (state_q == S_FETCH) & mem_ack;
  assign pc_write   = (state_q == S_FETCH) & mem_ack;
  assign instr_done = ctrl_q.done | ((state_q == S_MEM_WR) & mem_ack);

  // zero steers the datapath's conditional PC load, not the sequencing.
  logic unused_zero;
  assign unused_zero = zero;

endmodule

// File: tb/tb_multicycle_ctrl.sv
module tb_multicycle_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] opcode;
  logic       zero;
  logic       mem_ack;
  logic       mem_req, mem_we, iord, ir_write, pc_write, pc_write_cond;
  logic       branch_ne, pc_src, alu_src_a;
  logic [1:0] alu_src_b;
  logic [2:0] alu_ctrl;
  logic       reg_dst, mem_to_reg, reg_write, instr_done, halted;
  logic [3:0] state;

  multicycle_ctrl dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .zero(zero), .mem_ack(mem_ack),
    .mem_req(mem_req), .mem_we(mem_we), .iord(iord), .ir_write(ir_write),
    .pc_write(pc_write), .pc_write_cond(pc_write_cond), .branch_ne(branch_ne),
    .pc_src(pc_src), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .alu_ctrl(alu_ctrl), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
    .reg_write(reg_write), .instr_done(instr_done), .halted(halted),
    .state(state)
  );

  always #5 clk = ~clk;

  // Expected state encodings
  localparam logic [3:0] ST_IDLE = 4'd0, ST_FETCH = 4'd1, ST_DECODE = 4'd2,
    ST_EXEC_R = 4'd3, ST_EXEC_I = 4'd4, ST_MEM_ADDR = 4'd5, ST_MEM_RD = 4'd6,
    ST_MEM_WR = 4'd7, ST_WB_ALU = 4'd8, ST_WB_MEM = 4'd9, ST_BRANCH = 4'd10,
    ST_HALT = 4'd11;

  typedef struct packed {
    logic       mem_req, mem_we, iord, ir_write, pc_write, pc_write_cond;
    logic       branch_ne, pc_src, alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_ctrl;
    logic       reg_dst, mem_to_reg, reg_write, instr_done, halted;
    logic [3:0] state;
  } obs_t;

  typedef struct {
    obs_t       exp;
    logic       ack;
    logic [3:0] op;
  } cyc_t;

  typedef struct {
    logic [3:0] op;
    int         fw;
    int         dw;
    int         exp_len;
  } vec_t;

  int   errors = 0;
  int   checks = 0;
  cyc_t q[$];

  function automatic obs_t sample();
    obs_t o;
    o.mem_req = mem_req; o.mem_we = mem_we; o.iord = iord;
    o.ir_write = ir_write; o.pc_write = pc_write;
    o.pc_write_cond = pc_write_cond; o.branch_ne = branch_ne;
    o.pc_src = pc_src; o.alu_src_a = alu_src_a; o.alu_src_b = alu_src_b;
    o.alu_ctrl = alu_ctrl; o.reg_dst = reg_dst; o.mem_to_reg = mem_to_reg;
    o.reg_write = reg_write; o.instr_done = instr_done; o.halted = halted;
    o.state = state;
    return o;
  endfunction

  task automatic check_obs(input string name, input obs_t act, input obs_t exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: outputs got %h required %h (state got %0d required %0d)",
               name, act, exp, act.state, exp.state);
    end
  endtask

  task automatic check_val(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d required %0d", name, act, exp);
    end
  endtask

  // ---------------- reference model: expected per-cycle outputs ----------
  function automatic obs_t st(input logic [3:0] s);
    obs_t o;
    o = '0;
    o.state = s;
    return o;
  endfunction

  function automatic logic [2:0] r_alu(input logic [3:0] op);
    case (op)
      4'd0: return 3'b010;
      4'd1: return 3'b110;
      4'd2: return 3'b000;
      4'd3: return 3'b001;
      default: return 3'b111;
    endcase
  endfunction

  function automatic int base_len(input logic [3:0] op);
    if (op == 4'd8 || op == 4'd9) return 3;
    if (op == 4'd5) return 5;
    return 4;
  endfunction

  task automatic push(input obs_t o, input logic ack, input logic [3:0] op);
    cyc_t c;
    c.exp = o; c.ack = ack; c.op = op;
    q.push_back(c);
  endtask

  task automatic push_fetch_decode(input logic [3:0] op, input int fw);
    obs_t o;
    logic [3:0] junk;
    junk = 4'($urandom);
    o = st(ST_FETCH);
    o.mem_req = 1; o.alu_src_b = 2'b01; o.alu_ctrl = 3'b010;
    for (int i = 0; i < fw; i++) push(o, 1'b0, junk);
    o.ir_write = 1; o.pc_write = 1;
    push(o, 1'b1, junk);
    o = st(ST_DECODE);
    o.alu_src_b = 2'b11; o.alu_ctrl = 3'b010;
    push(o, 1'($urandom), op);
  endtask

  task automatic build(input logic [3:0] op, input int fw, input int dw);
    obs_t o;
    push_fetch_decode(op, fw);
    if (op <= 4'd3 || op == 4'd7 || op == 4'd4) begin
      o = (op == 4'd4) ? st(ST_EXEC_I) : st(ST_EXEC_R);
      o.alu_src_a = 1;
      o.alu_src_b = (op == 4'd4) ? 2'b10 : 2'b00;
      o.alu_ctrl  = (op == 4'd4) ? 3'b010 : r_alu(op);
      push(o, 1'($urandom), op);
      o = st(ST_WB_ALU);
      o.reg_write = 1; o.instr_done = 1; o.reg_dst = (op != 4'd4);
      push(o, 1'($urandom), op);
    end else if (op == 4'd5 || op == 4'd6) begin
      o = st(ST_MEM_ADDR);
      o.alu_src_a = 1; o.alu_src_b = 2'b10; o.alu_ctrl = 3'b010;
      push(o, 1'($urandom), op);
      o = (op == 4'd5) ? st(ST_MEM_RD) : st(ST_MEM_WR);
      o.mem_req = 1; o.iord = 1; o.mem_we = (op == 4'd6);
      for (int i = 0; i < dw; i++) push(o, 1'b0, op);
      o.instr_done = (op == 4'd6);
      push(o, 1'b1, op);
      if (op == 4'd5) begin
        o = st(ST_WB_MEM);
        o.reg_write = 1; o.mem_to_reg = 1; o.instr_done = 1;
        push(o, 1'($urandom), op);
      end
    end else begin
      o = st(ST_BRANCH);
      o.alu_src_a = 1; o.alu_src_b = 2'b00; o.alu_ctrl = 3'b110;
      o.pc_write_cond = 1; o.pc_src = 1; o.branch_ne = op[0];
      o.instr_done = 1;
      push(o, 1'($urandom), op);
    end
  endtask

  // Applies the queued cycles; called and returning at posedge+1.
  task automatic run_q(input string name, output int done_at);
    done_at = -1;
    for (int i = 0; i < q.size(); i++) begin
      opcode  = q[i].op;
      mem_ack = q[i].ack;
      zero    = 1'($urandom);
      @(negedge clk);
      check_obs($sformatf("%s_c%0d", name, i), sample(), q[i].exp);
      if (instr_done === 1'b1 && done_at < 0) done_at = i + 1;
      @(posedge clk);
      #1;
    end
    q.delete();
  endtask

  // Releases a low rst_n at a negedge; returns at posedge+1 (in FETCH).
  task automatic reset_release(input string name);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_obs({name, "_idle"}, sample(), st(ST_IDLE));
    @(posedge clk);
    #1;
  endtask

  vec_t vecs[8];

  initial begin
    int   len;
    obs_t h;
    logic [3:0] legal[10];

    vecs[0] = '{4'd0, 0, 0, 4};   // ADD zero-wait
    vecs[1] = '{4'd5, 0, 2, 7};   // LW with 2-cycle data wait
    vecs[2] = '{4'd6, 0, 0, 4};   // SW
    vecs[3] = '{4'd9, 0, 0, 3};   // BNE
    vecs[4] = '{4'd8, 0, 0, 3};   // BEQ
    vecs[5] = '{4'd4, 1, 0, 5};   // ADDI, one fetch wait
    vecs[6] = '{4'd7, 2, 0, 6};   // SLT, two fetch waits
    vecs[7] = '{4'd1, 0, 0, 4};   // SUB
    legal = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9};

    rst_n = 1'b0; opcode = 4'd0; zero = 1'b0; mem_ack = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_obs("reset_hold", sample(), st(ST_IDLE));
    reset_release("rst0");

    // Reset asserted in FETCH with mem_req high
    mem_ack = 1'b0;
    @(negedge clk);
    check_val("fetch_req", int'(mem_req), 1);
    #2;
    rst_n = 1'b0;
    #1;
    check_obs("rst_in_fetch", sample(), st(ST_IDLE));
    reset_release("rst1");
    @(negedge clk);
    check_val("fetch_after_rst", int'(state), int'(ST_FETCH));
    check_val("req_after_rst", int'(mem_req), 1);
    @(posedge clk);
    #1;
    // Still in FETCH (no ack given above)

    // Directed table
    for (int v = 0; v < 8; v++) begin
      build(vecs[v].op, vecs[v].fw, vecs[v].dw);
      run_q($sformatf("vec%0d", v), len);
      check_val($sformatf("vec%0d_latency", v), len, vecs[v].exp_len);
    end

    // Randomized instruction stream
    for (int n = 0; n < 150; n++) begin
      logic [3:0] op;
      int fw, dw, exp_len;
      op = legal[$urandom_range(0, 9)];
      fw = $urandom_range(0, 3);
      dw = $urandom_range(0, 3);
      exp_len = base_len(op) + fw + ((op == 4'd5 || op == 4'd6) ? dw : 0);
      build(op, fw, dw);
      run_q($sformatf("rnd%0d", n), len);
      check_val($sformatf("rnd%0d_latency", n), len, exp_len);
    end

    // Illegal opcode: DECODE then HALT, absorbing
    push_fetch_decode(4'hF, 0);
    run_q("ill", len);
    h = st(ST_HALT);
    h.halted = 1;
    for (int i = 0; i < 20; i++) begin
      opcode  = 4'($urandom);
      mem_ack = 1'($urandom);
      @(negedge clk);
      check_obs($sformatf("halt_c%0d", i), sample(), h);
      @(posedge clk);
      #1;
    end
    #2;
    rst_n = 1'b0;
    mem_ack = 1'b0;
    #1;
    check_obs("halt_rst", sample(), st(ST_IDLE));
    reset_release("rst2");

    // One instruction after recovering from HALT
    build(4'd2, 0, 0);
    run_q("post_halt", len);
    check_val("post_halt_latency", len, 4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: sim time exceeded bound, required completion");
    $fatal(1, "timeout");
  end

endmodule
